// File: rtl/img_scale_copier_pkg.sv
// rtl/img_scale_copier_pkg.sv - scale-mode encodings, copy FSM states and address widths
// Shared with the VGA top, which uses the same mode to destination-size mapping.
package img_scale_copier_pkg;

  localparam int ADDR_W = 19;
  localparam int CNT_W  = 10;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    SCALE_X2   = 2'b00,
    SCALE_HALF = 2'b01,
    SCALE_X1   = 2'b10
  } scale_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } copy_state_e;

  // Mode 2'b11 falls through to the x1 size, same as 2'b10.
  function automatic logic [CNT_W-1:0] dst_w(input logic [1:0] sel, input int img_w);
    case (sel)
      SCALE_X2:   return CNT_W'(320);
      SCALE_HALF: return CNT_W'(80);
      default:    return CNT_W'(img_w);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] dst_h(input logic [1:0] sel, input int img_h);
    case (sel)
      SCALE_X2:   return CNT_W'(240);
      SCALE_HALF: return CNT_W'(60);
      default:    return CNT_W'(img_h);
    endcase
  endfunction

endpackage

// File: rtl/img_scale_copier_addr_gen.sv
// rtl/img_scale_copier_addr_gen.sv - destination raster counters and source/destination address generation
// Exposes an edge-pixel flag only when SCALE_BORDER_EN is defined.
module scale_addr_gen
  import img_scale_copier_pkg::*;
#(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic              clk_50MHz,
  input  logic              vga_reset,
  input  logic              clr,
  input  logic              en,
  input  logic [1:0]        sel,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last
`ifdef SCALE_BORDER_EN
  ,
  output logic              edge_px
`endif
);

  logic [CNT_W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [CNT_W-1:0] w, h, w_m1, h_m1;
  addr_t            sx, sy;

  assign w    = dst_w(sel, IMG_W);
  assign h    = dst_h(sel, IMG_H);
  assign w_m1 = w - CNT_W'(1);
  assign h_m1 = h - CNT_W'(1);
  assign last = (dx_q == w_m1) && (dy_q == h_m1);

`ifdef SCALE_BORDER_EN
  assign edge_px = (dx_q == '0) || (dx_q == w_m1) || (dy_q == '0) || (dy_q == h_m1);
`endif

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clr) begin
      dx_d = '0;
      dy_d = '0;
    end else if (en) begin
      if (dx_q == w_m1) begin
        dx_d = '0;
        dy_d = (dy_q == h_m1) ? '0 : dy_q + CNT_W'(1);
      end else begin
        dx_d = dx_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    case (sel)
      SCALE_X2: begin
        sx = ADDR_W'(dx_q >> 1);
        sy = ADDR_W'(dy_q >> 1);
      end
      SCALE_HALF: begin
        sx = ADDR_W'(dx_q) << 1;
        sy = ADDR_W'(dy_q) << 1;
      end
      default: begin
        sx = ADDR_W'(dx_q);
        sy = ADDR_W'(dy_q);
      end
    endcase
  end

  assign rom_addr = sy * ADDR_W'(IMG_W) + sx;
  assign wr_addr  = ADDR_W'(dy_q) * ADDR_W'(w) + ADDR_W'(dx_q);

  always_ff @(posedge clk_50MHz or posedge vga_reset) begin
    if (vga_reset) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

endmodule

// File: rtl/img_scale_copier.sv
// rtl/img_scale_copier.sv - scaled ROM-to-framebuffer copier: copy FSM and ROM-latency write pipeline
// Optional feature macro SCALE_BORDER_EN replaces edge pixels with BORDER_COLOR.
module img_scale_copier
  import img_scale_copier_pkg::*;
#(
  parameter int         IMG_W        = 160,
  parameter int         IMG_H        = 120,
  parameter int         ROM_LAT      = 2,
  parameter logic [7:0] BORDER_COLOR = 8'hFF
) (
  input  logic              clk_50MHz,
  input  logic              vga_reset,
  input  logic              start,
  input  logic [1:0]        seletor,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [7:0]        ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done
);

  copy_state_e state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic        pend_q, pend_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  drain_q, drain_d;
  logic        go, launch, issue, last, use_border;
  addr_t       wr_addr;

  logic [ROM_LAT-1:0]             vld_q, vld_d;
  logic [ROM_LAT-1:0][ADDR_W-1:0] wa_q, wa_d;

  // A mode mismatch while parked acts as a start request.
  assign go     = start || pend_q || (seletor != sel_q);
  assign launch = go && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign issue  = (state_q == ST_RUN);

  scale_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_addr_gen (
    .clk_50MHz (clk_50MHz),
    .vga_reset (vga_reset),
    .clr       (launch),
    .en        (issue),
    .sel       (sel_q),
    .rom_addr  (rom_addr),
    .wr_addr   (wr_addr),
    .last      (last)
`ifdef SCALE_BORDER_EN
    ,
    .edge_px   (edge_px)
`endif
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (launch) begin
          state_d = ST_RUN;
          sel_d   = seletor;
          pend_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (last) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 3'(ROM_LAT - 1)) state_d = ST_DONE;
        else drain_d = drain_q + 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);

    vld_d[0] = issue;
    wa_d[0]  = wr_addr;
    for (int i = 1; i < ROM_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      wa_d[i]  = wa_q[i-1];
    end
  end

  always_ff @(posedge clk_50MHz or posedge vga_reset) begin
    if (vga_reset) begin
      state_q <= ST_IDLE;
      sel_q   <= SCALE_X1;
      pend_q  <= 1'b1;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= '0;
      wa_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      wa_q    <= wa_d;
    end
  end

`ifdef SCALE_BORDER_EN
  logic               edge_px;
  logic [ROM_LAT-1:0] brd_q, brd_d;

  always_comb begin
    brd_d[0] = edge_px;
    for (int i = 1; i < ROM_LAT; i++) brd_d[i] = brd_q[i-1];
  end

  always_ff @(posedge clk_50MHz or posedge vga_reset) begin
    if (vga_reset) brd_q <= '0;
    else brd_q <= brd_d;
  end

  assign use_border = brd_q[ROM_LAT-1];
`else
  assign use_border = 1'b0;
`endif

  assign ram_wren   = vld_q[ROM_LAT-1];
  assign ram_wraddr = wa_q[ROM_LAT-1];
  assign ram_data   = !ram_wren ? 8'h00 : (use_border ? BORDER_COLOR : rom_data);
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_img_scale_copier.sv
// tb/tb_img_scale_copier.sv - directed self-checking bench for img_scale_copier
module tb_img_scale_copier;

  localparam int ROM_LAT = 2;
  localparam int NPIX    = 76800;
`ifdef SCALE_BORDER_EN
  localparam bit BORDER_ON = 1'b1;
`else
  localparam bit BORDER_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        vga_reset, start;
  logic [1:0]  seletor;
  logic [18:0] rom_addr, ram_wraddr;
  logic [7:0]  rom_data, ram_data;
  logic        ram_wren, busy, done;

  img_scale_copier #(
    .IMG_W        (160),
    .IMG_H        (120),
    .ROM_LAT      (ROM_LAT),
    .BORDER_COLOR (8'hFF)
  ) dut (
    .clk_50MHz  (clk),
    .vga_reset  (vga_reset),
    .start      (start),
    .seletor    (seletor),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ram_wraddr (ram_wraddr),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .busy       (busy),
    .done       (done)
  );

  initial forever #10 clk = ~clk;

  function automatic logic [7:0] rom_f(input int a);
    return 8'((a * 7) ^ (a >> 7) ^ 32'h5A);
  endfunction

  function automatic int px(input bit brd, input int src);
    return (BORDER_ON && brd) ? 32'hFF : int'(rom_f(src));
  endfunction

  logic [18:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_addr;
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_f(int'(rom_pipe[ROM_LAT-1]));

  int tests = 0, fails = 0;
  int cyc = 0, rel_cyc = 0;
  int wr_cnt, dups, first_cyc, first_addr, first_data, done_cyc, done_rises = 0;
  logic done_prev = 1'b0;
  logic [7:0] fb [0:NPIX-1];
  int hits [0:NPIX-1];

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_cnt = 0; dups = 0; first_cyc = -1; first_addr = -1; first_data = -1; done_cyc = -1;
    rel_cyc = cyc;
    for (int i = 0; i < NPIX; i++) hits[i] = 0;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (ram_wren) begin
      if (wr_cnt == 0) begin
        first_cyc = cyc - rel_cyc; first_addr = int'(ram_wraddr); first_data = int'(ram_data);
      end
      if (int'(ram_wraddr) < NPIX) begin
        if (hits[ram_wraddr] != 0) dups++;
        hits[ram_wraddr]++;
        fb[ram_wraddr] = ram_data;
      end else dups++;
      wr_cnt++;
    end
    if (done && !done_prev) begin
      done_rises++; done_cyc = cyc - rel_cyc;
    end
    done_prev = done;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int r0 = done_rises;
    int n = 0;
    while (done_rises == r0 && n < bound) begin step(); n++; end
    chk({tag, " done reached"}, int'(done_rises > r0), 1);
  endtask

  task automatic wait_writes(input string tag, input int target, input int bound);
    int n = 0;
    while (wr_cnt < target && n < bound) begin step(); n++; end
    chk({tag, " writes reached"}, int'(wr_cnt >= target), 1);
  endtask

  task automatic check_cover(input string tag, input int n);
    int miss = 0;
    for (int i = 0; i < n; i++) if (hits[i] != 1) miss++;
    chk({tag, " each addr once"}, miss, 0);
    chk({tag, " dups"}, dups, 0);
  endtask

  initial begin
    vga_reset = 1'b1; start = 1'b0; seletor = 2'b10;
    step(); step();
    chk("rst wren", int'(ram_wren), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst rom_addr", int'(rom_addr), 0);
    chk("rst wraddr", int'(ram_wraddr), 0);
    chk("rst data", int'(ram_data), 0);

    // Copy launched by reset release alone, mode x1.
    clear_mon();
    vga_reset = 1'b0;
    wait_done("x1", 30000);
    chk("x1 first cycle", first_cyc, ROM_LAT + 1);
    chk("x1 first addr", first_addr, 0);
    chk("x1 first data", first_data, px(1, 0));
    chk("x1 done cycle", done_cyc, 19200 + ROM_LAT + 1);
    chk("x1 writes", wr_cnt, 19200);
    check_cover("x1", 19200);
    chk("x1 px159", int'(fb[159]), px(1, 159));
    chk("x1 px160", int'(fb[160]), px(1, 160));
    chk("x1 px161", int'(fb[161]), px(0, 161));
    chk("x1 px19199", int'(fb[19199]), px(1, 19199));
    chk("x1 busy at done", int'(busy), 0);
    step(); step(); step();
    chk("x1 parked writes", wr_cnt, 19200);
    chk("x1 parked done", int'(done), 1);

    // Seletor change while parked restarts in decimate mode.
    clear_mon();
    seletor = 2'b01;
    wait_done("half", 6000);
    chk("half done cycle", done_cyc, 4800 + ROM_LAT + 1);
    chk("half writes", wr_cnt, 4800);
    check_cover("half", 4800);
    chk("half px0", int'(fb[0]), px(1, 0));
    chk("half px81", int'(fb[81]), px(0, 322));
    chk("half px4799", int'(fb[4799]), px(1, 19038));

    // Explicit start pulse; a second pulse mid-copy is ignored.
    clear_mon();
    start = 1'b1; step(); start = 1'b0;
    chk("start busy", int'(busy), 1);
    chk("start done clr", int'(done), 0);
    wait_writes("start mid", 2000, 2500);
    start = 1'b1; step(); start = 1'b0;
    wait_done("start", 6000);
    chk("start done cycle", done_cyc, 4800 + ROM_LAT + 1);
    step(); step(); step();
    chk("start ignored writes", wr_cnt, 4800);
    chk("start ignored done", int'(done), 1);

    // Mode change mid-copy completes the x1 copy, then auto-starts x2.
    clear_mon();
    seletor = 2'b10;
    wait_writes("sw", 5000, 6000);
    seletor = 2'b00;
    wait_done("sw", 20000);
    chk("sw writes", wr_cnt, 19200);
    chk("sw done cycle", done_cyc, 19200 + ROM_LAT + 1);
    check_cover("sw", 19200);
    chk("sw px5000", int'(fb[5000]), px(0, 5000));
    clear_mon();
    step();
    chk("sw done pulse", int'(done), 0);
    chk("sw x2 busy", int'(busy), 1);
    wait_writes("x2", 1000, 1200);
    chk("x2 px0", int'(fb[0]), px(1, 0));
    chk("x2 px1", int'(fb[1]), px(1, 0));
    chk("x2 px320", int'(fb[320]), px(1, 0));
    chk("x2 px321", int'(fb[321]), px(0, 0));
    chk("x2 px641", int'(fb[641]), px(0, 160));
    chk("x2 px643", int'(fb[643]), px(0, 161));
    chk("x2 dups", dups, 0);

    // Reset mid-copy aborts immediately and relaunches from address 0.
    vga_reset = 1'b1;
    #1;
    chk("abort wren now", int'(ram_wren), 0);
    chk("abort busy now", int'(busy), 0);
    step(); step();
    chk("abort wren held", int'(ram_wren), 0);
    clear_mon();
    vga_reset = 1'b0;
    wait_writes("relaunch", 700, 1000);
    chk("relaunch first cycle", first_cyc, ROM_LAT + 1);
    chk("relaunch first addr", first_addr, 0);
    chk("relaunch first data", first_data, px(1, 0));
    chk("relaunch px321", int'(fb[321]), px(0, 0));
    chk("relaunch dups", dups, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
